// File: rtl/memory_access.sv
// rtl/memory_access.sv - MEM pipeline stage: data-memory load/store handshake and MEM/WB register (optional MEM_ENDIAN_SWAP_EN)
module memory_access #(
  parameter int ADDR_W = 30
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              WriteBack_3,
  input  logic [1:0]        Mem_3,
  input  logic [31:0]       ALU_result_3,
  input  logic [31:0]       writedata_3,
  input  logic [4:0]        Rd_3,
  input  logic              DCACHE_stall,
  input  logic [31:0]       DCACHE_rdata,
  output logic              DCACHE_ren,
  output logic              DCACHE_wen,
  output logic [ADDR_W-1:0] DCACHE_addr,
  output logic [31:0]       DCACHE_wdata,
  output logic              memory_stall,
  output logic              WriteBack_4,
  output logic [4:0]        Rd_4,
  output logic [31:0]       writeback_data_4
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]  state;
  logic [0:0]  state_next;
  logic        is_access;
  logic        is_load;
  logic [31:0] load_data;

  // Only the two one-hot encodings are real accesses; 2'b11 behaves like 2'b00.
  assign is_access = Mem_3[1] ^ Mem_3[0];
  assign is_load   = (Mem_3 == 2'b10);

  // Byte addresses become word addresses; the low two bits are dropped silently.
  assign DCACHE_addr = ADDR_W'(ALU_result_3[31:2]);

`ifdef MEM_ENDIAN_SWAP_EN
  assign DCACHE_wdata = {writedata_3[7:0], writedata_3[15:8], writedata_3[23:16], writedata_3[31:24]};
  assign load_data    = {DCACHE_rdata[7:0], DCACHE_rdata[15:8], DCACHE_rdata[23:16], DCACHE_rdata[31:24]};
`else
  assign DCACHE_wdata = writedata_3;
  assign load_data    = DCACHE_rdata;
`endif

  // Request/stall decode and next state; reset drops any request at once.
  always_comb begin
    DCACHE_ren   = 1'b0;
    DCACHE_wen   = 1'b0;
    memory_stall = 1'b0;
    state_next   = state;
    case (state)
      IDLE: begin
        if (is_access) begin
          DCACHE_ren   = Mem_3[1];
          DCACHE_wen   = Mem_3[0];
          memory_stall = 1'b1;
          state_next   = WAIT;
        end
      end
      WAIT: begin
        // EX/MEM is frozen while we wait, so the request is re-driven from it.
        DCACHE_ren   = Mem_3[1] & is_access;
        DCACHE_wen   = Mem_3[0] & is_access;
        memory_stall = DCACHE_stall;
        if (!DCACHE_stall) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (!rst_n) begin
      DCACHE_ren   = 1'b0;
      DCACHE_wen   = 1'b0;
      memory_stall = 1'b0;
    end
  end

  // Access state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // MEM/WB register: advances whenever the pipeline is not frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      WriteBack_4      <= 1'b0;
      Rd_4             <= 5'd0;
      writeback_data_4 <= 32'd0;
    end else if (!memory_stall) begin
      WriteBack_4      <= WriteBack_3;
      Rd_4             <= Rd_3;
      writeback_data_4 <= is_load ? load_data : ALU_result_3;
    end
  end

endmodule
